out_port_8bit: RTL

Parallel output port register for the TMP8 core: it captures 8-bit CPU writes and drives the 8-bit bus that feeds the bit splitter, which fans the bits out to LEDs and pins. It supports four bitwise write operations. An optional timed pulse mode holds a written value for a fixed number of cycles, then restores the previous value. A ready/busy handshake blocks writes while a pulse is in progress.

---
 rtl/tmp8_io_pkg.sv | 32 +++
 rtl/out_port_8bit.sv | 79 +++++++
 2 files changed

// File: rtl/tmp8_io_pkg.sv
// TMP8 I/O shared definitions.
// Write-op encodings, port FSM states and the bitwise op helper.
package tmp8_io_pkg;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_SET  = 2'b01;
    localparam logic [1:0] OP_CLR  = 2'b10;
    localparam logic [1:0] OP_TGL  = 2'b11;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_PULSE = 1'b1
    } port_state_t;

    function automatic logic [7:0] apply_op(
        input logic [1:0] op,
        input logic [7:0] cur,
        input logic [7:0] data
    );
        logic [7:0] res;
        res = data;
        unique case (1'b1)
            (op == OP_LOAD): res = data;
            (op == OP_SET):  res = cur | data;
            (op == OP_CLR):  res = cur & ~data;
            (op == OP_TGL):  res = cur ^ data;
            default:         res = data;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/out_port_8bit.sv
// TMP8 8-bit parallel output port.
// Bitwise writes, optional timed pulse with restore, ready/busy handshake.
module out_port_8bit
    import tmp8_io_pkg::*;
#(
    parameter logic [7:0] RESET_VALUE  = 8'h00,
    parameter int         PULSE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [1:0] wr_op,
    input  logic [7:0] wr_data,
    input  logic       wr_pulse,
    output logic       wr_ready,
    output logic [7:0] port_out,
    output logic       busy,
    output logic       changed
);

    localparam int CW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(PULSE_CYCLES - 1);

    port_state_t   state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [7:0]    saved, saved_nx;
    logic [7:0]    port_nx;

    // Ready depends on state only, so no input-to-output path.
    assign wr_ready = (state == ST_IDLE);
    assign busy     = ~wr_ready;

    // Register state, port value, pulse counter, saved value and change strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            saved    <= RESET_VALUE;
            port_out <= RESET_VALUE;
            changed  <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            saved    <= saved_nx;
            port_out <= port_nx;
            changed  <= (port_nx != port_out);
        end
    end

    // Next-state: accept writes in IDLE, count down and restore in PULSE.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        saved_nx = saved;
        port_nx  = port_out;
        unique case (state)
            ST_IDLE: begin
                if (wr_en) begin
                    port_nx = apply_op(wr_op, port_out, wr_data);
                    if (wr_pulse) begin
                        saved_nx = port_out;
                        cnt_nx   = CNT_INIT;
                        state_nx = ST_PULSE;
                    end
                end
            end
            ST_PULSE: begin
                if (cnt != '0) begin
                    cnt_nx = cnt - 1'b1;
                end else begin
                    port_nx  = saved;
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

endmodule
